// File: rtl/feeder_pkg.sv
// Shared types and constants for the UART-driven instruction feeder.
package feeder_pkg;

    typedef enum logic [1:0] {RX, ISSUE, DRAIN, TX} state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
    localparam int unsigned DRAIN_W        = 4;

    localparam logic [WORD_W-1:0] NOP_ADDI = 32'h0000_0013;

endpackage

// File: rtl/uart_inst_feeder_word_serializer.sv
// Emits a loaded 32-bit word as four little-endian bytes over a valid/ready link.
module word_serializer
    import feeder_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              done_c
);

    logic [WORD_W-1:0] shift;
    logic [BCNT_W-1:0] cnt;
    logic              xfer_c;

    assign xfer_c  = tx_valid && tx_ready;
    assign done_c  = xfer_c && (cnt == BCNT_W'(BYTES_PER_WORD - 1));
    assign tx_data = shift[BYTE_W-1:0];

    // Load wins over a transfer; the byte on tx_data only moves when accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift    <= '0;
            cnt      <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shift    <= load_word;
            cnt      <= '0;
            tx_valid <= 1'b1;
        end else if (xfer_c) begin
            shift <= shift >> BYTE_W;
            cnt   <= cnt + BCNT_W'(1);
            if (done_c) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_inst_feeder.sv
// Assembles an instruction from UART bytes, issues it to the CPU for one fetch
// cycle, drains with NOPs, then returns the sampled result word over UART.
module uart_inst_feeder
    import feeder_pkg::*;
#(
    parameter logic [31:0] NOP_INST     = NOP_ADDI,
    parameter int unsigned DRAIN_CYCLES = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] inst_mem_in,
    output logic [31:0] inst_mem_out,
    input  logic [31:0] result_word,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy
);

    state_t              state, state_d;
    logic [BCNT_W-1:0]   byte_cnt, byte_cnt_d;
    logic [DRAIN_W-1:0]  drain_cnt, drain_cnt_d;
    logic [WORD_W-1:0]   asm_word, asm_word_d;
    logic [WORD_W-1:0]   inst_d;
    logic                rx_ready_d, busy_d;
    logic                accept_c, load_c, done_c;
    logic                pc_unused;

    // The CPU PC never selects anything; this block is the only instruction source.
    assign pc_unused = ^inst_mem_in;

    assign accept_c = (state == RX) && rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RX;
            byte_cnt     <= '0;
            drain_cnt    <= '0;
            asm_word     <= '0;
            inst_mem_out <= NOP_INST;
            rx_ready     <= 1'b1;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            byte_cnt     <= byte_cnt_d;
            drain_cnt    <= drain_cnt_d;
            asm_word     <= asm_word_d;
            inst_mem_out <= inst_d;
            rx_ready     <= rx_ready_d;
            busy         <= busy_d;
        end
    end

    // Next state plus next values of the registered outputs.
    always_comb begin
        state_d     = state;
        byte_cnt_d  = byte_cnt;
        drain_cnt_d = drain_cnt;
        asm_word_d  = asm_word;
        inst_d      = NOP_INST;
        load_c      = 1'b0;

        unique case (state)
            RX: begin
                if (accept_c) begin
                    for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
                        if (byte_cnt == BCNT_W'(k)) begin
                            asm_word_d[k*BYTE_W +: BYTE_W] = rx_data;
                        end
                    end
                    if (byte_cnt == BCNT_W'(BYTES_PER_WORD - 1)) begin
                        byte_cnt_d = '0;
                        state_d    = ISSUE;
                        inst_d     = asm_word_d;
                    end else begin
                        byte_cnt_d = byte_cnt + BCNT_W'(1);
                    end
                end
            end
            ISSUE: begin
                drain_cnt_d = '0;
                state_d     = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
                    load_c  = 1'b1;
                    state_d = TX;
                end else begin
                    drain_cnt_d = drain_cnt + DRAIN_W'(1);
                end
            end
            TX: begin
                if (done_c) begin
                    state_d = RX;
                end
            end
            default: state_d = RX;
        endcase

        rx_ready_d = (state_d == RX);
        busy_d     = (state_d != RX);
    end

    word_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .load_word (result_word),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done_c    (done_c)
    );

endmodule
